// File: rtl/div_pkg.sv
// Shared types and constants for the restoring shift-and-subtract divider.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step-counter width for a given operand width; one extra bit so the count reaches WIDTH.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/shift_sub_divider_if.sv
// Start/done handshake and operand/result bus of the divider.
interface shift_sub_divider_if #(
    parameter int unsigned WIDTH = div_pkg::DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned WIDTH = div_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] dvsr_ext;

    // The old remainder MSB is kept as t's top bit so the compare never loses it.
    always_comb begin
        t        = {rem, q_msb};
        dvsr_ext = {1'b0, divisor};
        q_bit    = (t >= dvsr_ext);
        next_rem = q_bit ? WIDTH'(t - dvsr_ext) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned divider: one quotient bit per clock with a start/done handshake.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    shift_sub_divider_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] q_r, q_next;
    logic [WIDTH-1:0] rem_r, rem_next;
    logic [WIDTH-1:0] dvsr_r, dvsr_next;
    logic [CW-1:0]    cnt_r, cnt_next;
    logic             dbz_r, dbz_next;
    logic             busy_r, done_r;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .q_msb    (q_r[WIDTH-1]),
        .divisor  (dvsr_r),
        .next_rem (step_rem),
        .q_bit    (step_bit)
    );

    // State, working registers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_r    <= '0;
            rem_r  <= '0;
            dvsr_r <= '0;
            cnt_r  <= '0;
            dbz_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            q_r    <= q_next;
            rem_r  <= rem_next;
            dvsr_r <= dvsr_next;
            cnt_r  <= cnt_next;
            dbz_r  <= dbz_next;
            busy_r <= (state_next == RUN);
            done_r <= (state_next == DONE);
        end
    end

    // Next-state and datapath updates; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        q_next     = q_r;
        rem_next   = rem_r;
        dvsr_next  = dvsr_r;
        cnt_next   = cnt_r;
        dbz_next   = dbz_r;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        q_next     = '1;
                        rem_next   = bus.dividend;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        q_next     = bus.dividend;
                        dvsr_next  = bus.divisor;
                        rem_next   = '0;
                        cnt_next   = '0;
                        dbz_next   = 1'b0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                q_next   = {q_r[WIDTH-2:0], step_bit};
                rem_next = step_rem;
                cnt_next = cnt_r + CW'(1);
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Results come straight from the working registers.
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = q_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider (WIDTH = 32).
module tb_shift_sub_divider;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shift_sub_divider_if #(.WIDTH(32)) bus ();

    shift_sub_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start in cycle 0; return the cycle of done (-1 on timeout) and number of busy cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
        lat   = -1;
        nbusy = 0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    int lat;
    int nbusy;
    int ndone;

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbz",  32'(bus.div_by_zero), 32'd0);
        chk("rst_quot", bus.quotient, 32'd0);
        chk("rst_rem",  bus.remainder, 32'd0);
        rst = 1'b0;
        tick();

        // 100 / 7
        run_op(32'd100, 32'd7, lat, nbusy);
        chk("100_7_lat",   32'(lat), 32'd33);
        chk("100_7_busy",  32'(nbusy), 32'd32);
        chk("100_7_quot",  bus.quotient, 32'd14);
        chk("100_7_rem",   bus.remainder, 32'd2);
        chk("100_7_dbz",   32'(bus.div_by_zero), 32'd0);
        tick();
        chk("100_7_pulse", 32'(bus.done), 32'd0);
        chk("100_7_hold",  bus.quotient, 32'd14);

        // dividend smaller than divisor
        run_op(32'd5, 32'd9, lat, nbusy);
        chk("5_9_lat",  32'(lat), 32'd33);
        chk("5_9_quot", bus.quotient, 32'd0);
        chk("5_9_rem",  bus.remainder, 32'd5);
        tick();

        run_op(32'hFFFF_FFFF, 32'd1, lat, nbusy);
        chk("max_1_lat",  32'(lat), 32'd33);
        chk("max_1_quot", bus.quotient, 32'hFFFF_FFFF);
        chk("max_1_rem",  bus.remainder, 32'd0);
        tick();

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nbusy);
        chk("max_max_quot", bus.quotient, 32'd1);
        chk("max_max_rem",  bus.remainder, 32'd0);
        tick();

        // divide by zero
        run_op(32'd1234, 32'd0, lat, nbusy);
        chk("dbz_lat",  32'(lat), 32'd1);
        chk("dbz_busy", 32'(nbusy), 32'd0);
        chk("dbz_flag", 32'(bus.div_by_zero), 32'd1);
        chk("dbz_quot", bus.quotient, 32'hFFFF_FFFF);
        chk("dbz_rem",  bus.remainder, 32'd1234);
        tick();
        chk("dbz_pulse", 32'(bus.done), 32'd0);
        chk("dbz_hold",  32'(bus.div_by_zero), 32'd1);

        // flag cleared by the next accepted start
        run_op(32'd20, 32'd6, lat, nbusy);
        chk("20_6_dbz",  32'(bus.div_by_zero), 32'd0);
        chk("20_6_quot", bus.quotient, 32'd3);
        chk("20_6_rem",  bus.remainder, 32'd2);
        tick();

        // start during RUN is ignored
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        tick();
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            if (c == 10) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        chk("ign_lat",  32'(lat), 32'd33);
        chk("ign_quot", bus.quotient, 32'd14);
        chk("ign_rem",  bus.remainder, 32'd2);
        tick();
        run_op(32'd50, 32'd5, lat, nbusy);
        chk("next_lat",  32'(lat), 32'd33);
        chk("next_quot", bus.quotient, 32'd10);
        chk("next_rem",  bus.remainder, 32'd0);
        tick();

        // reset aborts a running division
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        chk("abort_busy15", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_quot", bus.quotient, 32'd0);
        chk("abort_rem",  bus.remainder, 32'd0);
        chk("abort_dbz",  32'(bus.div_by_zero), 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
            tick();
        end
        chk("abort_quiet", 32'(ndone), 32'd0);
        run_op(32'd9, 32'd3, lat, nbusy);
        chk("9_3_lat",  32'(lat), 32'd33);
        chk("9_3_quot", bus.quotient, 32'd3);
        chk("9_3_rem",  bus.remainder, 32'd0);
        tick();

        // reset and start together: reset wins
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 32'd40;
        bus.divisor  = 32'd3;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("rst_start_busy", 32'(bus.busy), 32'd0);
        chk("rst_start_done", 32'(bus.done), 32'd0);
        chk("rst_start_quot", bus.quotient, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
